// File: rtl/lsu_rv32i_pkg.sv
// Shared encodings for the RV32I load/store unit: funct3 sizes, memory store types, FSM states,
// plus small decode helpers used by the control path.
package lsu_rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST_SPLIT = 2'd1,
    LD_HI    = 2'd2
  } lsu_state_e;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f3_storetype(input logic [2:0] f3);
    case (f3)
      F3_H:    return ST_SH;
      F3_W:    return ST_SW;
      default: return ST_SB;
    endcase
  endfunction

  // Index of the final byte in a split store (2 bytes for halves, 4 for words).
  function automatic logic [1:0] f3_last_idx(input logic [2:0] f3);
    return (f3 == F3_W) ? 2'd3 : 2'd1;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Selects the addressed bytes out of a two-word window and sign/zero-extends them.
// Latency: purely combinational.
// Backpressure: none; output follows the inputs.
module lsu_load_ext
  import lsu_rv32i_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  assign shifted = 32'(data >> {offset, 3'b000});

  always_comb begin
    result = 32'h0;
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    result = shifted;
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit in front of an async-read, falling-edge-write data memory.
// Latency: 1 cycle aligned/illegal, N cycles misaligned N-byte store, 2 cycles misaligned load.
// Backpressure: req_ready drops while a split access is in flight; responses cannot stall.
module lsu_rv32i
  import lsu_rv32i_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dmem_we,
  output logic [1:0]  dmem_storetype,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic [31:0] lo_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        accept;
  logic        req_legal;
  logic        req_mis;
  logic [7:0]  split_byte;
  logic [63:0] ext_data;
  logic [1:0]  ext_off;
  logic [2:0]  ext_f3;
  logic [31:0] ext_out;

  assign req_ready  = (state_q == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign req_legal  = f3_legal(req_store, req_funct3);
  assign req_mis    = f3_misaligned(req_funct3, req_addr[1:0]);
  assign split_byte = 8'(wdata_q >> {idx_q, 3'b000});

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  lsu_load_ext u_load_ext (
    .data   (ext_data),
    .offset (ext_off),
    .funct3 (ext_f3),
    .result (ext_out)
  );

  // In IDLE the memory port follows req_* directly so the first access lands in the accept cycle.
  // Write enable is masked by reset so an aborted split store stops immediately.
  always_comb begin
    state_d        = state_q;
    dmem_we        = 1'b0;
    dmem_storetype = f3_storetype(req_funct3);
    dmem_addr      = req_addr;
    dmem_wdata     = req_wdata;
    ext_data       = {32'h0, dmem_rdata};
    ext_off        = req_addr[1:0];
    ext_f3         = req_funct3;
    case (state_q)
      IDLE: begin
        if (req_store && req_mis) begin
          dmem_storetype = ST_SB;
          dmem_wdata     = {24'h0, req_wdata[7:0]};
        end
        dmem_we = req_valid && req_store && req_legal && !reset;
        if (accept && req_legal && req_mis) begin
          state_d = req_store ? ST_SPLIT : LD_HI;
        end
      end
      ST_SPLIT: begin
        dmem_we        = !reset;
        dmem_storetype = ST_SB;
        dmem_addr      = addr_q + {30'h0, idx_q};
        dmem_wdata     = {24'h0, split_byte};
        if (idx_q == last_q) begin
          state_d = IDLE;
        end
      end
      LD_HI: begin
        dmem_addr = addr_q + 32'd4;
        ext_data  = {dmem_rdata, lo_q};
        ext_off   = addr_q[1:0];
        ext_f3    = f3_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      f3_q         <= 3'h0;
      idx_q        <= 2'h0;
      last_q       <= 2'h0;
      lo_q         <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            idx_q   <= 2'd1;
            last_q  <= f3_last_idx(req_funct3);
            lo_q    <= dmem_rdata;
            if (!req_legal) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_mis) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= req_store ? 32'h0 : ext_out;
            end
          end
        end
        ST_SPLIT: begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == last_q) begin
            resp_valid_q <= 1'b1;
          end
        end
        LD_HI: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= ext_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rv32i.sv
// Self-checking bench for lsu_rv32i: directed scenarios plus randomized requests
// checked against a byte-addressed reference memory.
module tb_lsu_rv32i;

  localparam int LOGN = 10;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_we;
  logic [1:0]  dmem_storetype;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int failures = 0;

  // Fixture memory (word organised, falling-edge write) and the byte-level oracle.
  logic [31:0] mem  [0:255];
  logic [7:0]  rmem [0:1023];
  logic        load_mem;

  logic        we_log   [0:LOGN-1];
  logic        rdy_log  [0:LOGN-1];
  logic [31:0] addr_log [0:LOGN-1];
  logic [1:0]  st_log   [0:LOGN-1];
  logic [31:0] wd_log   [0:LOGN-1];
  logic [31:0] rd_obs;
  logic        err_obs;
  int          lat_obs;

  lsu_rv32i dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_store      (req_store),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .dmem_we        (dmem_we),
    .dmem_storetype (dmem_storetype),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dmem_rdata = mem[dmem_addr[9:2]];

  logic [31:0] wtmp;
  int          lane;
  int          nbytes;
  always @(negedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]};
    end else if (dmem_we) begin
      wtmp   = mem[dmem_addr[9:2]];
      lane   = int'(dmem_addr[1:0]);
      nbytes = (dmem_storetype == 2'b00) ? 1 : (dmem_storetype == 2'b01) ? 2 : 4;
      for (int b = 0; b < 4; b++)
        if (b < nbytes && lane + b < 4) wtmp[8*(lane+b) +: 8] = dmem_wdata[8*b +: 8];
      mem[dmem_addr[9:2]] <= wtmp;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ai;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ai = a + 32'(i);
      w[8*i +: 8] = rmem[ai[9:0]];
    end
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rword(input int widx);
    return {rmem[4*widx+3], rmem[4*widx+2], rmem[4*widx+1], rmem[4*widx]};
  endfunction

  // Starts at posedge+1 of an idle cycle; returns at posedge+1 of the cycle after the response.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    lat_obs = -1;
    rd_obs  = 32'hx;
    err_obs = 1'bx;
    for (int c = 0; c < LOGN; c++) begin
      we_log[c] = 1'b0; rdy_log[c] = 1'b0; addr_log[c] = 32'h0; st_log[c] = 2'h0; wd_log[c] = 32'h0;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int c = 0; c < LOGN; c++) begin
      @(negedge clock);
      rdy_log[c]  = req_ready;
      we_log[c]   = dmem_we;
      addr_log[c] = dmem_addr;
      st_log[c]   = dmem_storetype;
      wd_log[c]   = dmem_wdata;
      if (c > 0 && resp_valid) begin
        lat_obs = c; rd_obs = resp_rdata; err_obs = resp_err;
      end
      @(posedge clock); #1;
      if (c == 0) begin
        req_valid = 1'b0; req_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      if (lat_obs >= 0) break;
    end
  endtask

  task automatic exec(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
    int sz, elat, enw, nw;
    logic legal, mis;
    logic [31:0] erd, ai;
    sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    mis   = (a % 32'(sz)) != 0;
    erd   = (legal && !st) ? m_load(f3, a) : 32'h0;
    elat  = !legal ? 1 : !mis ? 1 : st ? sz : 2;
    enw   = (legal && st) ? (mis ? sz : 1) : 0;
    do_req(st, f3, a, wd);
    nw = 0;
    for (int c = 0; c < LOGN; c++)
      if (lat_obs < 0 || c <= lat_obs) nw += int'(we_log[c]);
    chk({tag, " latency"}, 32'(lat_obs), 32'(elat));
    chk({tag, " err"}, {31'h0, err_obs}, {31'h0, !legal});
    chk({tag, " rdata"}, rd_obs, erd);
    chk({tag, " writes"}, 32'(nw), 32'(enw));
    if (legal && st)
      for (int i = 0; i < sz; i++) begin
        ai = a + 32'(i);
        rmem[ai[9:0]] = wd[8*i +: 8];
      end
  endtask

  initial begin
    logic [31:0] e1, e2, a, wd;
    logic        st;
    logic [2:0]  f3;
    int          nresp;

    reset = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'h0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) rmem[i] = 8'($urandom);
    {rmem[32'h3FF], rmem[32'h3FE], rmem[32'h3FD], rmem[32'h3FC]} = 32'hAABBCCDD;
    {rmem[3], rmem[2], rmem[1], rmem[0]} = 32'h11223344;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; load_mem = 1'b0;

    @(negedge clock);
    chk("reset req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset resp_err", {31'h0, resp_err}, 32'h0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset dmem_we", {31'h0, dmem_we}, 32'h0);
    @(posedge clock); #1;

    // Misaligned word load spanning the top of the address space.
    exec("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    chk("lw_wrap value", rd_obs, 32'h3344AABB);
    chk("lw_wrap hi addr", addr_log[1], 32'h00000002);

    exec("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    exec("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_10 value", rd_obs, 32'hDEADBEEF);
    exec("lb_13", 1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb_13 value", rd_obs, 32'hFFFFFFDE);
    exec("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
    chk("lbu_13 value", rd_obs, 32'h000000DE);
    exec("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0);
    chk("lhu_12 value", rd_obs, 32'h0000DEAD);
    exec("lh_10", 1'b0, 3'b001, 32'h10, 32'h0);
    chk("lh_10 value", rd_obs, 32'hFFFFBEEF);

    wd = 32'h44332211;
    exec("sw_21", 1'b1, 3'b010, 32'h21, wd);
    for (int c = 0; c < 4; c++) begin
      chk("sw_21 we", {31'h0, we_log[c]}, 32'h1);
      chk("sw_21 addr", addr_log[c], 32'h21 + 32'(c));
      chk("sw_21 type", {30'h0, st_log[c]}, 32'h0);
      chk("sw_21 byte", {24'h0, wd_log[c][7:0]}, {24'h0, wd[8*c +: 8]});
      if (c > 0) chk("sw_21 ready low", {31'h0, rdy_log[c]}, 32'h0);
    end
    exec("lw_21", 1'b0, 3'b010, 32'h21, 32'h0);
    chk("lw_21 value", rd_obs, 32'h44332211);

    exec("st_illegal", 1'b1, 3'b011, 32'h40, 32'h12345678);

    // Reset lands in the third cycle of a split word store.
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h21; req_wdata = 32'hDDCCBBAA;
    @(negedge clock);
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("abort we in reset", {31'h0, dmem_we}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort ready after reset", {31'h0, req_ready}, 32'h1);
    nresp = int'(resp_valid);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      nresp += int'(resp_valid) + int'(dmem_we);
    end
    chk("abort no resp", 32'(nresp), 32'h0);
    rmem[32'h21] = 8'hAA;
    rmem[32'h22] = 8'hBB;
    chk("abort word 0x20", mem[8], rword(8));
    chk("abort word 0x24", mem[9], rword(9));
    @(posedge clock); #1;

    // Back-to-back: second request accepted in the first one's response cycle.
    e1 = m_load(3'b010, 32'h10);
    e2 = m_load(3'b100, 32'h13);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge clock);
    chk("b2b ready 0", {31'h0, req_ready}, 32'h1);
    @(posedge clock); #1;
    req_funct3 = 3'b100; req_addr = 32'h13;
    @(negedge clock);
    chk("b2b resp1 valid", {31'h0, resp_valid}, 32'h1);
    chk("b2b ready 1", {31'h0, req_ready}, 32'h1);
    chk("b2b resp1 rdata", resp_rdata, e1);
    @(posedge clock); #1 req_valid = 1'b0;
    @(negedge clock);
    chk("b2b resp2 valid", {31'h0, resp_valid}, 32'h1);
    chk("b2b resp2 rdata", resp_rdata, e2);
    @(posedge clock); #1;

    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      wd = $urandom;
      exec("rand", st, f3, a, wd);
    end

    for (int w = 0; w < 256; w++) chk("final mem", mem[w], rword(w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
